tmr_ctrl: RTL and testbench
===========================

# tmr_ctrl

Programmable interval timer controller that sequences an internal 8-bit up-counter. It accepts start, stop and pause commands and captures a period. It emits a terminal-count pulse and a level interrupt with an acknowledge handshake. One-shot and auto-reload modes are supported. It sits between a host/control FSM and the counter datapath and owns all counter enable and clear decisions.

## Interface
- W, default 8: counter and period width in bits.
- Clk  in  1: the only clock; all state updates on its rising edge.
- Res  in  1: reset, synchronous, active-high; wins over every other input.
- start  in  1: begin a timing run; sampled only in IDLE.
- stop  in  1: abort the run from any state.
- mode  in  1: 0 = one-shot, 1 = auto-reload; captured with start.
- hold  in  1: pause counting while high; effective in RUN only.
- period  in  W: terminal period N (1..2^W-1); captured with start.
- ack  in  1: clears irq (and ovr when configured).
- busy  out  1: high in LOAD and RUN.
- cnt  out  W: current counter value.
- tc  out  1: one-cycle terminal-count pulse.
- irq  out  1: level interrupt; set on tc, held until ack.
- ovr  out  1: sticky overrun flag.
- err  out  1: one-cycle pulse when start is rejected because period == 0.

## Operation
- States are IDLE, LOAD and RUN.
- Reset values: state = IDLE, cnt = 0, busy = 0, tc = 0, irq = 0, ovr = 0, err = 0, captured period/mode = 0.
- IDLE: if start & !stop & period != 0, capture period/mode, clear cnt, go to LOAD. If start & period == 0, stay in IDLE and pulse err.
- LOAD: one cycle with cnt = 0. Always go to RUN; hold is ignored here.
- RUN with hold = 1: cnt frozen, no terminal evaluation, no tc.
- RUN with hold = 0 and cnt == N-1: cnt <= 0 and tc <= 1. In one-shot mode go to IDLE; in auto-reload mode stay in RUN.
- RUN otherwise: cnt <= cnt + 1.
- cnt arithmetic is modulo 2^W but never wraps in practice, because the terminal is reached at N-1 ≤ 2^W-2.
- stop, in any state: go to IDLE and set cnt <= 0; stop beats start, hold and terminal in the same cycle. irq and ovr are unaffected by stop.
- start while busy is ignored. A change to period or mode mid-run is ignored until the next accepted start.
- irq: set on any cycle where tc is set. Cleared by ack only when no tc is set in that same cycle; tc and ack together leave irq = 1.
- ack while irq = 0 has no effect.
- Reset mid-run: the next cycle shows all reset values; no tc is generated.

## Timing
- Start sampled at edge k: LOAD after k, RUN after k+1. With N = period, cnt shows 0..N-1 across edges k+1..k+N, and tc and irq are high after edge k+1+N.
- Latency from accepted start to first tc is N+1 cycles. In auto-reload mode, tc repeats every N cycles, plus one cycle for every cycle hold is high.
- N = 1: cnt stays 0 and tc fires on every RUN cycle (auto-reload).
- One-shot: busy falls in the same cycle tc is high.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- TMR_CTRL_OVERRUN_EN defined:
  - ovr is set when tc is set while irq is already 1 and ack is low in that cycle.
  - ovr stays set until ack or Res.
- Without the macro: ovr is tied to 0 and no overrun logic is generated.

## Structure
- Shared package/include tmr_ctrl_pkg holds:
  - state encodings: IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10;
  - mode constants MODE_ONESHOT = 0 and MODE_RELOAD = 1;
  - default width W = 8.
- One sub-module, tmr_cnt_core: a W-bit up-counter with synchronous clear and enable inputs, driven by the FSM. The FSM, capture registers and irq/ovr logic live in tmr_ctrl.

## Test plan
- Reset then one-shot, period = 3, start pulse at cycle 0:
  - busy = 1 for cycles 1..4; cnt sequence 0,0,1,2,0;
  - tc and irq high after edge 4; busy = 0 after edge 4; ack at cycle 6 gives irq = 0.
- Auto-reload, period = 5:
  - tc at edges 6, 11, 16;
  - hold high for 2 cycles during the second interval moves the next tc to edge 13, then 18.
- start with period = 0 gives one err pulse, with busy, cnt and tc unchanged. start and stop asserted together in IDLE gives no state change.
- Auto-reload, period = 2, no ack, macro defined:
  - ovr is set on the second tc;
  - ack with a tc in the same cycle leaves irq = 1 and ovr = 0.
  - Macro undefined: ovr stays 0 throughout.
- Mid-run events, period = 10:
  - stop at cnt = 4 gives IDLE, cnt = 0, irq unchanged;
  - Res asserted at cnt = 7 gives all outputs at reset values on the next cycle and no tc.

Source files
------------

// File: rtl/tmr_ctrl_pkg.sv
// tmr_ctrl_pkg: state encodings, mode constants and default width for tmr_ctrl.
package tmr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10} state_t;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD = 1'b1;
  localparam int DEF_W = 8;
endpackage

// File: rtl/tmr_cnt_core.sv
// tmr_cnt_core: W-bit up-counter with synchronous clear and enable.
module tmr_cnt_core #(parameter int W = 8) (
  input  logic         Clk,
  input  logic         Res,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge Clk)
    cnt <= (Res || clr) ? '0 : en ? cnt + W'(1) : cnt;
endmodule

// File: rtl/tmr_ctrl.sv
// tmr_ctrl: interval timer FSM with one-shot/auto-reload, tc pulse and irq/ack.
// Define TMR_CTRL_OVERRUN_EN to build the sticky overrun flag.
module tmr_ctrl import tmr_ctrl_pkg::*; #(parameter int W = DEF_W) (
  input  logic         Clk,
  input  logic         Res,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic         hold,
  input  logic [W-1:0] period,
  input  logic         ack,
  output logic         busy,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         irq,
  output logic         ovr,
  output logic         err
);
  state_t state, state_nx;
  logic [W-1:0] per_q;
  logic mode_q, accept, term, fire, clr, en;
  assign accept = (state == IDLE) && start && !stop && (period != '0);
  assign term = cnt == per_q - W'(1);
  // stop overrides hold and terminal in the same cycle
  assign fire = (state == RUN) && !hold && term && !stop;
  assign en = (state == RUN) && !hold && !term && !stop;
  assign clr = stop || accept || fire;
  always_ff @(posedge Clk)
    state <= Res ? IDLE : state_nx;
  always_comb
    state_nx = stop ? IDLE :
               (state == IDLE) ? (accept ? LOAD : IDLE) :
               (state == LOAD) ? RUN :
               (state == RUN) ? ((fire && mode_q == MODE_ONESHOT) ? IDLE : RUN) : IDLE;
  always_comb
    busy = state != IDLE;
  always_ff @(posedge Clk) begin
    if (Res) begin
      per_q <= '0;
      mode_q <= 1'b0;
      tc <= 1'b0;
      err <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (accept) begin
        per_q <= period;
        mode_q <= mode;
      end
      tc <= fire;
      err <= (state == IDLE) && start && !stop && (period == '0);
      irq <= fire || (irq && !ack);
    end
  end
`ifdef TMR_CTRL_OVERRUN_EN
  always_ff @(posedge Clk)
    ovr <= (Res || ack) ? 1'b0 : (fire && irq) ? 1'b1 : ovr;
`else
  assign ovr = 1'b0;
`endif
  tmr_cnt_core #(.W(W)) u_cnt (.Clk(Clk), .Res(Res), .clr(clr), .en(en), .cnt(cnt));
endmodule

// File: tb/tb_tmr_ctrl.sv
// tb_tmr_ctrl: directed self-checking bench for tmr_ctrl.
module tb_tmr_ctrl;
  logic Clk = 0, Res = 1, start = 0, stop = 0, mode = 0, hold = 0, ack = 0;
  logic [7:0] period = 0;
  logic busy, tc, irq, ovr, err;
  logic [7:0] cnt;
  int errors = 0, checks = 0;
`ifdef TMR_CTRL_OVERRUN_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  tmr_ctrl #(.W(8)) dut (.Clk(Clk), .Res(Res), .start(start), .stop(stop), .mode(mode),
    .hold(hold), .period(period), .ack(ack), .busy(busy), .cnt(cnt), .tc(tc),
    .irq(irq), .ovr(ovr), .err(err));

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Res = 1;
    tick();
    tick();
    checks++;
    if ({busy, cnt, tc, irq, ovr, err} !== 13'b0) begin
      errors++;
      $display("FAIL reset: busy=%b cnt=%0d tc=%b irq=%b ovr=%b err=%b, want all 0", busy, cnt, tc, irq, ovr, err);
    end
    Res = 0;
    tick();
    checks++;
    if ({busy, cnt, tc, irq} !== 11'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b cnt=%0d tc=%b irq=%b, want 0", busy, cnt, tc, irq);
    end
  endtask

  task automatic test_oneshot;
    logic [7:0] exp_cnt [5] = '{0, 0, 1, 2, 0};
    logic exp_busy [5] = '{1, 1, 1, 1, 0};
    logic exp_tc [5] = '{0, 0, 0, 0, 1};
    period = 3; mode = 0; start = 1;
    for (int e = 0; e < 5; e++) begin
      tick();
      start = 0;
      checks++;
      if (cnt !== exp_cnt[e] || busy !== exp_busy[e] || tc !== exp_tc[e] || irq !== exp_tc[e]) begin
        errors++;
        $display("FAIL oneshot edge %0d: cnt=%0d busy=%b tc=%b irq=%b, want cnt=%0d busy=%b tc=%b irq=%b",
                 e, cnt, busy, tc, irq, exp_cnt[e], exp_busy[e], exp_tc[e], exp_tc[e]);
      end
    end
    tick();
    checks++;
    if (tc !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_irq_hold: tc=%b irq=%b, want tc=0 irq=1", tc, irq);
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_ack: irq=%b, want 0", irq);
    end
  endtask

  task automatic test_reload_hold;
    logic exp;
    period = 5; mode = 1; start = 1;
    tick();
    start = 0;
    for (int e = 1; e <= 18; e++) begin
      hold = (e == 8 || e == 9);
      tick();
      exp = (e == 6 || e == 13 || e == 18);
      checks++;
      if (tc !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL reload edge %0d: tc=%b busy=%b, want tc=%b busy=1", e, tc, busy, exp);
      end
    end
    hold = 0;
    stop = 1;
    tick();
    stop = 0;
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (busy !== 1'b0 || cnt !== 8'd0 || irq !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reload_stop_ack: busy=%b cnt=%0d irq=%b ovr=%b, want 0 0 0 0", busy, cnt, irq, ovr);
    end
  endtask

  task automatic test_err;
    period = 0; start = 1;
    tick();
    start = 0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cnt !== 8'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%b busy=%b cnt=%0d tc=%b, want 1 0 0 0", err, busy, cnt, tc);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: err=%b, want 0", err);
    end
    period = 5; start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || cnt !== 8'd0 || err !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL start_stop: busy=%b cnt=%0d err=%b tc=%b, want 0 0 0 0", busy, cnt, err, tc);
    end
  endtask

  task automatic test_overrun;
    period = 2; mode = 1; start = 1;
    tick();
    start = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 3) begin
        checks++;
        if (tc !== 1'b1 || irq !== 1'b1 || ovr !== 1'b0) begin
          errors++;
          $display("FAIL ovr_first_tc: tc=%b irq=%b ovr=%b, want 1 1 0", tc, irq, ovr);
        end
      end
    end
    checks++;
    if (tc !== 1'b1 || ovr !== OVR_ON) begin
      errors++;
      $display("FAIL ovr_second_tc: tc=%b ovr=%b, want tc=1 ovr=%b", tc, ovr, OVR_ON);
    end
    tick();
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (tc !== 1'b1 || irq !== 1'b1 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL ack_with_tc: tc=%b irq=%b ovr=%b, want 1 1 0", tc, irq, ovr);
    end
    stop = 1;
    tick();
    stop = 0;
    checks++;
    if (busy !== 1'b0 || cnt !== 8'd0 || tc !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL ovr_stop: busy=%b cnt=%0d tc=%b irq=%b, want 0 0 0 1", busy, cnt, tc, irq);
    end
  endtask

  task automatic test_midrun;
    period = 10; mode = 0; start = 1;
    tick();
    start = 0;
    for (int e = 1; e <= 5; e++) tick();
    checks++;
    if (cnt !== 8'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_cnt4: cnt=%0d busy=%b, want 4 1", cnt, busy);
    end
    stop = 1;
    tick();
    stop = 0;
    checks++;
    if (busy !== 1'b0 || cnt !== 8'd0 || tc !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL midrun_stop: busy=%b cnt=%0d tc=%b irq=%b, want 0 0 0 1", busy, cnt, tc, irq);
    end
    start = 1;
    tick();
    start = 0;
    for (int e = 1; e <= 8; e++) tick();
    checks++;
    if (cnt !== 8'd7) begin
      errors++;
      $display("FAIL midrun_cnt7: cnt=%0d, want 7", cnt);
    end
    Res = 1;
    tick();
    Res = 0;
    checks++;
    if ({busy, cnt, tc, irq, ovr, err} !== 13'b0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b cnt=%0d tc=%b irq=%b ovr=%b err=%b, want all 0", busy, cnt, tc, irq, ovr, err);
    end
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (tc !== 1'b0 || busy !== 1'b0 || cnt !== 8'd0) begin
        errors++;
        $display("FAIL post_reset %0d: tc=%b busy=%b cnt=%0d, want 0 0 0", e, tc, busy, cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload_hold();
    test_err();
    test_overrun();
    test_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
